// File: rtl/bus_arb_pkg.sv
// Shared encodings and helpers for the common-bus arbiter.
package bus_arb_pkg;

    localparam int SEL_W        = 3;
    localparam int NUM_SRC      = 7;
    localparam int MAX_HOLD_DEF = 4;

    typedef enum logic [SEL_W-1:0] {
        SEL_NONE = 3'd0,
        SEL_AR   = 3'd1,
        SEL_PC   = 3'd2,
        SEL_DR   = 3'd3,
        SEL_AC   = 3'd4,
        SEL_IR   = 3'd5,
        SEL_TR   = 3'd6,
        SEL_MEM  = 3'd7
    } sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    function automatic logic [NUM_SRC-1:0] sel_decode(input logic [SEL_W-1:0] s);
        logic [NUM_SRC-1:0] one_hot;
        one_hot = '0;
        if (s != SEL_NONE) one_hot = {{(NUM_SRC-1){1'b0}}, 1'b1} << (s - 3'd1);
        return one_hot;
    endfunction

    // Round-robin successor: 7 wraps back to 1, select 0 is never a source.
    function automatic logic [SEL_W-1:0] next_src(input logic [SEL_W-1:0] s);
        return (s == SEL_MEM) ? SEL_AR : s + 3'd1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin search: first requester at or after pointer, wrapping
// 7->1, skipping the source named by exclude (0 excludes nobody).
module rr_picker
    import bus_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   pointer,
    input  logic [SEL_W-1:0]   exclude,
    output logic               valid,
    output logic [SEL_W-1:0]   winner
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        valid  = 1'b0;
        winner = SEL_NONE;
        cand   = pointer;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!valid && cand != exclude && |(req & sel_decode(cand))) begin
                valid  = 1'b1;
                winner = cand;
            end
            cand = next_src(cand);
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the basic computer's common bus; select drives the bus mux.
// Define BUS_ARB_TIMEOUT_EN to force release of a locked owner after MAX_HOLD cycles.
module bus_arbiter
    import bus_arb_pkg::*;
`ifdef BUS_ARB_TIMEOUT_EN
    #(parameter int MAX_HOLD = MAX_HOLD_DEF)
`endif
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] lock,
    output logic [SEL_W-1:0]   select,
    output logic [NUM_SRC-1:0] grant,
    output logic               busy,
    output logic               timeout
);

    state_t           state;
    logic [SEL_W-1:0] pointer;
    logic             pick_valid;
    logic [SEL_W-1:0] pick_winner;
    logic [SEL_W-1:0] pick_exclude;
    logic             owner_req;
    logic             owner_keep;
    logic [SEL_W-1:0] nxt_sel;
    logic [SEL_W-1:0] nxt_ptr;
    logic             nxt_fresh;

    // The current owner is excluded so the picker always reports a competitor.
    assign pick_exclude = (state == ST_OWN) ? select : SEL_NONE;

    rr_picker u_picker (
        .req     (req),
        .pointer (pointer),
        .exclude (pick_exclude),
        .valid   (pick_valid),
        .winner  (pick_winner)
    );

    assign owner_req  = |(req & grant);
    assign owner_keep = |(req & lock & grant);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_expired;
    logic              nxt_timeout;

    assign hold_expired = (hold_cnt == HOLD_LAST);
`endif

    always_comb begin
        nxt_sel   = select;
        nxt_ptr   = pointer;
        nxt_fresh = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        nxt_timeout = 1'b0;
`endif
        if (state == ST_IDLE) begin
            if (pick_valid) begin
                nxt_sel   = pick_winner;
                nxt_fresh = 1'b1;
            end
        end else if (owner_keep) begin
`ifdef BUS_ARB_TIMEOUT_EN
            if (hold_expired && pick_valid) begin
                nxt_sel     = pick_winner;
                nxt_fresh   = 1'b1;
                nxt_timeout = 1'b1;
            end
`endif
        end else if (pick_valid) begin
            nxt_sel   = pick_winner;
            nxt_fresh = 1'b1;
        end else if (owner_req) begin
            // Unlocked owner asking again with no rival: a fresh ownership period.
            nxt_fresh = 1'b1;
        end else begin
            nxt_sel = SEL_NONE;
        end
        if (nxt_fresh) nxt_ptr = next_src(nxt_sel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            select  <= SEL_NONE;
            grant   <= '0;
            busy    <= 1'b0;
            pointer <= SEL_AR;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            state   <= (nxt_sel != SEL_NONE) ? ST_OWN : ST_IDLE;
            select  <= nxt_sel;
            grant   <= sel_decode(nxt_sel);
            busy    <= (nxt_sel != SEL_NONE);
            pointer <= nxt_ptr;
`ifdef BUS_ARB_TIMEOUT_EN
            if (nxt_fresh)          hold_cnt <= '0;
            else if (!hold_expired) hold_cnt <= hold_cnt + 1'b1;
            timeout <= nxt_timeout;
`endif
        end
    end

`ifndef BUS_ARB_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule
